// File: rtl/inbus_read_arbiter.sv
// ---------------------------------------------------------------------------
// inbus_read_arbiter
//   Shares the 8-bit input bus among NUM_REQ read requesters. A round-robin
//   arbiter picks one requester in IDLE, the FSM issues a single bus read
//   (ISSUE), captures the OR-combined peripheral reply (CAPTURE) and returns
//   it with a one-cycle one-hot ack (DONE). Only one read is ever in flight.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high
//   req         per-requester read request level
//   req_addr    requester i address in bits [8i+7:8i]
//   ack         one-cycle completion pulse, one-hot
//   rd_data     read data, valid while ack != 0, zero otherwise
//   busy        high in every state except IDLE
//   INBUS_ADDR  bus address, 0 when not issuing
//   INBUS_RE    bus read strobe
//   INBUS_DATA  OR of peripheral replies, one cycle after INBUS_RE
// ---------------------------------------------------------------------------
module inbus_read_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [8*NUM_REQ-1:0]    req_addr,
   output logic [NUM_REQ-1:0]      ack,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    busy,
   output logic [7:0]              INBUS_ADDR,
   output logic                    INBUS_RE,
   input  logic [DATA_WIDTH-1:0]   INBUS_DATA
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                  state_reg, state_next;
   logic [IDXW-1:0]         rr_reg, rr_next;
   logic [IDXW-1:0]         gnt_reg, gnt_next;
   logic [NUM_REQ-1:0]      ack_reg, ack_next;
   logic [DATA_WIDTH-1:0]   rd_data_reg, rd_data_next;
   logic                    busy_reg, busy_next;
   logic [7:0]              bus_addr_reg, bus_addr_next;
   logic                    bus_re_reg, bus_re_next;

   // Requests rotated so that slot 0 is the requester at the rr pointer;
   // the lowest asserted slot is the round-robin winner.
   logic [IDXW-1:0]         cand_idx [NUM_REQ];
   logic [NUM_REQ-1:0]      cand_req;
   logic [7:0]              addr_arr [NUM_REQ];
   logic                    grant_found;
   logic [IDXW-1:0]         grant_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         logic [IDXW:0] sum;
         logic [IDXW:0] wrapped;
         assign sum          = {1'b0, rr_reg} + (IDXW+1)'(gi);
         assign wrapped      = (sum >= (IDXW+1)'(NUM_REQ)) ? sum - (IDXW+1)'(NUM_REQ) : sum;
         assign cand_idx[gi] = wrapped[IDXW-1:0];
         assign cand_req[gi] = req[cand_idx[gi]];
         assign addr_arr[gi] = req_addr[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      grant_found = |cand_req;
      grant_idx   = '0;
      // Scan from the far end so the nearest slot to the pointer wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_req[k]) begin
            grant_idx = cand_idx[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         rr_reg       <= '0;
         gnt_reg      <= '0;
         ack_reg      <= '0;
         rd_data_reg  <= '0;
         busy_reg     <= 1'b0;
         bus_addr_reg <= 8'h00;
         bus_re_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rr_reg       <= rr_next;
         gnt_reg      <= gnt_next;
         ack_reg      <= ack_next;
         rd_data_reg  <= rd_data_next;
         busy_reg     <= busy_next;
         bus_addr_reg <= bus_addr_next;
         bus_re_reg   <= bus_re_next;
      end
   end

   // Every output is registered, so the values computed here appear during
   // the state being entered: RE/ADDR are set while leaving IDLE and are
   // visible in ISSUE; ack/rd_data are set while leaving CAPTURE and are
   // visible in DONE.
   always_comb begin
      state_next    = state_reg;
      rr_next       = rr_reg;
      gnt_next      = gnt_reg;
      ack_next      = '0;
      rd_data_next  = '0;
      busy_next     = 1'b0;
      bus_addr_next = 8'h00;
      bus_re_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant_found) begin
               state_next    = ISSUE;
               gnt_next      = grant_idx;
               busy_next     = 1'b1;
               bus_re_next   = 1'b1;
               bus_addr_next = addr_arr[grant_idx];
            end
         end
         ISSUE: begin
            state_next = CAPTURE;
            busy_next  = 1'b1;
         end
         CAPTURE: begin
            state_next         = DONE;
            busy_next          = 1'b1;
            rd_data_next       = INBUS_DATA;
            ack_next[gnt_reg]  = 1'b1;
         end
         DONE: begin
            state_next = IDLE;
            if (gnt_reg == IDXW'(NUM_REQ - 1)) begin
               rr_next = '0;
            end else begin
               rr_next = gnt_reg + IDXW'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign ack        = ack_reg;
   assign rd_data    = rd_data_reg;
   assign busy       = busy_reg;
   assign INBUS_ADDR = bus_addr_reg;
   assign INBUS_RE   = bus_re_reg;

endmodule

// File: tb/tb_inbus_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_inbus_read_arbiter
//   Two instances: a 2-requester arbiter for the main directed cases and a
//   4-requester one for the rotation/skip case. Each has a bus model whose
//   peripherals reply (addr ^ 0xA0) one cycle after RE. Expected bus
//   addresses and acks are queued when a read is launched; a negedge monitor
//   pops and compares whenever RE or ack is seen.
// ---------------------------------------------------------------------------
module tb_inbus_read_arbiter;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   logic [1:0]  req_a;
   logic [15:0] addr_a;
   logic [1:0]  ack_a;
   logic [7:0]  rd_a;
   logic        busy_a;
   logic [7:0]  bus_addr_a;
   logic        re_a;
   logic [7:0]  bus_data_a;

   logic [3:0]  req_b;
   logic [31:0] addr_b;
   logic [3:0]  ack_b;
   logic [7:0]  rd_b;
   logic        busy_b;
   logic [7:0]  bus_addr_b;
   logic        re_b;
   logic [7:0]  bus_data_b;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] q_addr_a [$];
   exp_t       q_ack_a  [$];
   logic [7:0] q_addr_b [$];
   exp_t       q_ack_b  [$];

   bit         garble;
   logic [7:0] reply_a, reply_b;
   logic       re_a_d;

   inbus_read_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8)) dut_a (
      .clk(clk), .reset(reset), .req(req_a), .req_addr(addr_a),
      .ack(ack_a), .rd_data(rd_a), .busy(busy_a),
      .INBUS_ADDR(bus_addr_a), .INBUS_RE(re_a), .INBUS_DATA(bus_data_a)
   );

   inbus_read_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut_b (
      .clk(clk), .reset(reset), .req(req_b), .req_addr(addr_b),
      .ack(ack_b), .rd_data(rd_b), .busy(busy_b),
      .INBUS_ADDR(bus_addr_b), .INBUS_RE(re_b), .INBUS_DATA(bus_data_b)
   );

   // Peripheral model: registered reply one cycle after RE, zero otherwise.
   always @(posedge clk) begin
      reply_a <= re_a ? (bus_addr_a ^ 8'hA0) : 8'h00;
      reply_b <= re_b ? (bus_addr_b ^ 8'hA0) : 8'h00;
      re_a_d  <= re_a;
   end
   // Garble mode: bus shows 0xFF except in the reply cycle, which shows 0x3C.
   assign bus_data_a = garble ? (re_a_d ? 8'h3C : 8'hFF) : reply_a;
   assign bus_data_b = reply_b;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (re_a) begin
            if (q_addr_a.size() == 0) check("a unexpected RE", 32'(bus_addr_a), 32'hFFFF);
            else check("a bus addr", 32'(bus_addr_a), 32'(q_addr_a.pop_front()));
         end
         if (ack_a != 2'b00) begin
            if (q_ack_a.size() == 0) check("a unexpected ack", 32'(ack_a), 32'h0);
            else begin
               exp_t e;
               e = q_ack_a.pop_front();
               check("a ack", 32'(ack_a), 32'(e.a));
               check("a rd_data", 32'(rd_a), 32'(e.d));
            end
         end else begin
            check("a rd_data idle", 32'(rd_a), 32'h0);
         end
         if (re_b) begin
            if (q_addr_b.size() == 0) check("b unexpected RE", 32'(bus_addr_b), 32'hFFFF);
            else check("b bus addr", 32'(bus_addr_b), 32'(q_addr_b.pop_front()));
         end
         if (ack_b != 4'b0000) begin
            if (q_ack_b.size() == 0) check("b unexpected ack", 32'(ack_b), 32'h0);
            else begin
               exp_t e;
               e = q_ack_b.pop_front();
               check("b ack", 32'(ack_b), 32'(e.a));
               check("b rd_data", 32'(rd_b), 32'(e.d));
            end
         end
      end
   end

   // One full read on dut_a; the caller has just driven req for cycle N.
   task automatic do_read_a(input logic [7:0] ea, input logic [1:0] eack,
                            input logic [7:0] ed, input bit drop);
      exp_t e;
      e.a = 8'(eack);
      e.d = ed;
      q_addr_a.push_back(ea);
      q_ack_a.push_back(e);
      tick();
      check("a N+1 RE", 32'(re_a), 32'h1);
      check("a N+1 ADDR", 32'(bus_addr_a), 32'(ea));
      check("a N+1 busy", 32'(busy_a), 32'h1);
      check("a N+1 ack", 32'(ack_a), 32'h0);
      if (drop) begin
         req_a  = 2'b00;
         addr_a = 16'h9999;
      end
      tick();
      check("a N+2 RE", 32'(re_a), 32'h0);
      check("a N+2 ADDR", 32'(bus_addr_a), 32'h0);
      check("a N+2 busy", 32'(busy_a), 32'h1);
      tick();
      check("a N+3 ack", 32'(ack_a), 32'(eack));
      check("a N+3 rd_data", 32'(rd_a), 32'(ed));
      check("a N+3 busy", 32'(busy_a), 32'h1);
      tick();
      check("a N+4 ack", 32'(ack_a), 32'h0);
      check("a N+4 rd_data", 32'(rd_a), 32'h0);
      check("a N+4 busy", 32'(busy_a), 32'h0);
   endtask

   task automatic do_read_b(input logic [7:0] ea, input logic [3:0] eack, input logic [7:0] ed);
      exp_t e;
      e.a = 8'(eack);
      e.d = ed;
      q_addr_b.push_back(ea);
      q_ack_b.push_back(e);
      tick();
      check("b N+1 RE", 32'(re_b), 32'h1);
      tick();
      tick();
      check("b N+3 ack", 32'(ack_b), 32'(eack));
      tick();
   endtask

   initial begin
      reset  = 1'b1;
      req_a  = 2'b00;
      addr_a = 16'h0000;
      req_b  = 4'b0000;
      addr_b = 32'h0;
      garble = 1'b0;
      tick();
      tick();
      check("reset ack", 32'(ack_a), 32'h0);
      check("reset rd_data", 32'(rd_a), 32'h0);
      check("reset busy", 32'(busy_a), 32'h0);
      check("reset ADDR", 32'(bus_addr_a), 32'h0);
      check("reset RE", 32'(re_a), 32'h0);
      check("reset b busy", 32'(busy_b), 32'h0);
      reset = 1'b0;

      // Single read from requester 0
      req_a  = 2'b01;
      addr_a = 16'h0005;
      do_read_a(8'h05, 2'b01, 8'hA5, 1'b0);
      req_a = 2'b00;

      // Both requesting right after reset: strict alternation
      reset = 1'b1;
      tick();
      tick();
      reset  = 1'b0;
      req_a  = 2'b11;
      addr_a = 16'h2010;
      do_read_a(8'h10, 2'b01, 8'hB0, 1'b0);
      do_read_a(8'h20, 2'b10, 8'h80, 1'b0);
      do_read_a(8'h10, 2'b01, 8'hB0, 1'b0);
      do_read_a(8'h20, 2'b10, 8'h80, 1'b0);
      req_a = 2'b00;

      // Bus noise outside the reply cycle must not be captured
      garble = 1'b1;
      req_a  = 2'b01;
      addr_a = 16'h0033;
      do_read_a(8'h33, 2'b01, 8'h3C, 1'b0);
      req_a  = 2'b00;
      garble = 1'b0;

      // Reset during CAPTURE aborts without ack, then a fresh read completes
      req_a  = 2'b10;
      addr_a = 16'h4400;
      q_addr_a.push_back(8'h44);
      tick();
      check("abort RE", 32'(re_a), 32'h1);
      tick();
      check("abort capture busy", 32'(busy_a), 32'h1);
      reset = 1'b1;
      tick();
      check("abort ack", 32'(ack_a), 32'h0);
      check("abort rd_data", 32'(rd_a), 32'h0);
      check("abort busy", 32'(busy_a), 32'h0);
      check("abort ADDR", 32'(bus_addr_a), 32'h0);
      check("abort RE cleared", 32'(re_a), 32'h0);
      reset = 1'b0;
      do_read_a(8'h44, 2'b10, 8'hE4, 1'b0);
      req_a = 2'b00;

      // req dropped and address changed after grant: read still completes
      req_a  = 2'b10;
      addr_a = 16'h5500;
      do_read_a(8'h55, 2'b10, 8'hF5, 1'b1);
      tick();
      check("no regrant after drop", 32'(re_a), 32'h0);

      // Four requesters: rotation 0,1,2,3,0 then requester 2 drops out
      req_b  = 4'b1111;
      addr_b = 32'h43424140;
      do_read_b(8'h40, 4'b0001, 8'hE0);
      do_read_b(8'h41, 4'b0010, 8'hE1);
      do_read_b(8'h42, 4'b0100, 8'hE2);
      do_read_b(8'h43, 4'b1000, 8'hE3);
      do_read_b(8'h40, 4'b0001, 8'hE0);
      req_b = 4'b1011;
      do_read_b(8'h41, 4'b0010, 8'hE1);
      do_read_b(8'h43, 4'b1000, 8'hE3);
      do_read_b(8'h40, 4'b0001, 8'hE0);
      do_read_b(8'h41, 4'b0010, 8'hE1);
      req_b = 4'b0000;

      tick();
      tick();
      check("a addr queue drained", 32'(q_addr_a.size()), 32'h0);
      check("a ack queue drained", 32'(q_ack_a.size()), 32'h0);
      check("b addr queue drained", 32'(q_addr_b.size()), 32'h0);
      check("b ack queue drained", 32'(q_ack_b.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
